// File: rtl/subtractor59_22_seq.sv
// Multi-cycle 59-bit minus zero-extended 22-bit subtractor, CHUNK bits per cycle via a registered borrow.
// Optional build macro SUB59_SATURATE_EN: clamp an underflowing result to zero and flag it in Diff[59].
module subtractor59_22_seq #(
    parameter int CHUNK = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [58:0] A,
    input  logic [21:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [59:0] Diff
);

    localparam int NCHUNK = (59 + CHUNK - 1) / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [59:0] SLICE_ONES = (60'd1 << CHUNK) - 60'd1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [58:0]     r_a;
    logic [58:0]     r_b;
    logic [59:0]     r_res;
    logic            r_borrow;
    logic [KW-1:0]   r_k;

    logic [6:0]       w_lo;
    logic [CHUNK-1:0] w_a_sl;
    logic [CHUNK-1:0] w_b_sl;
    logic [CHUNK:0]   w_sub;
    logic [58:0]      w_mask;
    logic [58:0]      w_ins;
    logic [58:0]      w_res_next;
    logic             w_borrow_out;
    logic             w_last;

    // Bits past 58 shift in as zero in both operands, so the sign bit of the
    // (CHUNK+1)-bit slice difference is the borrow-out even for a clipped last slice.
    assign w_lo         = 7'(r_k) * 7'(CHUNK);
    assign w_a_sl       = CHUNK'(r_a >> w_lo);
    assign w_b_sl       = CHUNK'(r_b >> w_lo);
    assign w_sub        = {1'b0, w_a_sl} - {1'b0, w_b_sl} - {{CHUNK{1'b0}}, r_borrow};
    assign w_borrow_out = w_sub[CHUNK];
    assign w_mask       = 59'(SLICE_ONES << w_lo);
    assign w_ins        = 59'({{(60 - CHUNK){1'b0}}, w_sub[CHUNK-1:0]} << w_lo);
    assign w_res_next   = (r_res[58:0] & ~w_mask) | (w_ins & w_mask);
    assign w_last       = (r_k == KW'(NCHUNK - 1));

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign Diff      = r_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_k      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a      <= A;
                        r_b      <= {37'b0, B};
                        r_borrow <= 1'b0;
                        r_k      <= '0;
                    end
                end
                S_RUN: begin
                    r_res[58:0] <= w_res_next;
                    r_borrow    <= w_borrow_out;
                    if (w_last) begin
                        r_k       <= '0;
                        r_res[59] <= w_borrow_out;
`ifdef SUB59_SATURATE_EN
                        if (w_borrow_out) begin
                            r_res <= {1'b1, 59'b0};
                        end
`endif
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
